muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and consumes its rs/rt read data.
- Executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers. MTHI and MTLO write HI/LO directly.
- Exposes busy/done so the pipeline controller stalls MFHI/MFLO and new mul/div ops until the result is ready.

---
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU,
// one iteration per cycle into architectural HI/LO, plus direct MTHI/MTLO writes.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rsdata,
    input  logic [WIDTH-1:0] rtdata,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_opb;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_last;
    logic [WIDTH:0]   w_msum;
    logic [AW-1:0]    w_mul_nxt;
    logic [WIDTH:0]   w_trial;
    logic [AW-1:0]    w_div_nxt;
    logic [AW-1:0]    w_prod_fix;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Operand magnitudes; op[0]=1 selects the unsigned variants.
    assign w_signed = ~op[0];
    assign w_sa     = w_signed & rsdata[WIDTH-1];
    assign w_sb     = w_signed & rtdata[WIDTH-1];
    assign w_mag_a  = w_sa ? (~rsdata + WIDTH'(1)) : rsdata;
    assign w_mag_b  = w_sb ? (~rtdata + WIDTH'(1)) : rtdata;

    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    assign w_msum    = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_msum, r_acc[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend bits shifting into quotient}.
    assign w_trial   = {r_acc[AW-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
    assign w_div_nxt = w_trial[WIDTH] ? {r_acc[AW-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // Sign fix; a zero divisor leaves |dividend| in the remainder, so its sign fix restores rsdata.
    assign w_quo      = r_acc[WIDTH-1:0];
    assign w_rem      = r_acc[AW-1:WIDTH];
    assign w_prod_fix = r_neg_q ? (~r_acc + AW'(1)) : r_acc;
    assign w_quo_fix  = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? (~w_quo + WIDTH'(1)) : w_quo);
    assign w_rem_fix  = r_neg_r ? (~w_rem + WIDTH'(1)) : w_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_div0   <= (rtdata == '0);
                        r_opb    <= w_mag_b;
                        r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end else begin
                        if (mthi) r_hi <= rsdata;
                        if (mtlo) r_lo <= rsdata;
                    end
                end
                ST_RUN: begin
                    r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_FIN: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[AW-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rsdata;
    logic [W-1:0]  rtdata;
    logic          mthi;
    logic          mtlo;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rsdata(rsdata), .rtdata(rtdata), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: {hi,lo} from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, res;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op and check latency, busy, result; optional check that done drops.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit tail);
        logic [63:0] exp;
        int n;
        int busy_lo;
        exp = model(o, a, b);
        op = o; rsdata = a; rtdata = b; start = 1'b1;
        tick();
        start = 1'b0;
        rsdata = $urandom;
        rtdata = $urandom;
        n = 0;
        busy_lo = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_lo++;
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(W + 1));
        chk("busy_run", 64'(busy_lo), 64'd0);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("result", {hi, lo}, exp);
        if (tail) begin
            tick();
            chk("done_pulse", {63'd0, done}, 64'd0);
            chk("hold", {hi, lo}, exp);
        end
    endtask

    initial begin
        logic [63:0] exp;
        int n;
        int dones;
        reset = 1'b1; start = 1'b0; op = 2'b00;
        rsdata = '0; rtdata = '0; mthi = 1'b0; mtlo = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        // Directed results
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
        chk("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("div_neg7by2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, 1'b1);
        chk("divu_100by7", {hi, lo}, {32'd2, 32'd14});
        run_op(2'b11, 32'h1234_5678, 32'd0, 1'b1);
        chk("divu_by0", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b1);
        chk("div_neg_by0", {hi, lo}, 64'hFFFF_FF00_FFFF_FFFF);

        // start/mthi while busy ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        op = 2'b00; rsdata = 32'd5; rtdata = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        op = 2'b11; rsdata = 32'h0000_AAAA; start = 1'b1; mthi = 1'b1;
        tick();
        start = 1'b0; mthi = 1'b0;
        n = 10;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("ign_latency", 64'(n), 64'(W + 1));
        chk("ign_result", {hi, lo}, {32'd0, 32'd30});
        tick();
        rsdata = 32'h55; mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        chk("mtlo_idle", {hi, lo}, {32'd0, 32'h55});

        // mthi+mtlo together, and start beats mthi/mtlo
        rsdata = 32'hCAFE_F00D; mthi = 1'b1; mtlo = 1'b1;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
        mthi = 1'b1; mtlo = 1'b1;
        op = 2'b01; rsdata = 32'd3; rtdata = 32'd4; start = 1'b1;
        tick();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("start_wins_hold", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("start_wins_res", {hi, lo}, 64'd12);

        // Reset mid-divide discards the result
        tick();
        op = 2'b10; rsdata = 32'd1000; rtdata = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        chk("midrst_nodone", 64'(dones), 64'd0);
        run_op(2'b10, 32'd1000, 32'hFFFF_FFF9, 1'b1);

        // mthi in the done cycle lands after the result
        run_op(2'b00, 32'd12345, 32'hFFFF_0000, 1'b0);
        exp = model(2'b00, 32'd12345, 32'hFFFF_0000);
        rsdata = 32'h1357_9BDF; mthi = 1'b1;
        tick();
        mthi = 1'b0;
        chk("mthi_done_cycle", {hi, lo}, {32'h1357_9BDF, exp[31:0]});
        chk("done_after_mthi", {63'd0, done}, 64'd0);

        // Randomized ops, some back-to-back from the done cycle
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
